ltc2344_conv_scheduler: RTL and testbench

Sequences conversions on the LTC2344 CMOS controller by generating its extTrig pulse and holding its softspan word stable for each conversion. Two trigger sources share the single ADC: a programmable periodic timer and a software request port with valid/ready handshake. Grants between the two are round-robin. The block waits for the controller's dataRdy, then publishes the four channel words with a source tag. It also flags a missed periodic trigger and a conversion that times out.

---
 rtl/ltc2344_conv_scheduler.sv | 156 +++++++++++++++
 tb/tb_ltc2344_conv_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2344_conv_scheduler.sv
// Conversion scheduler for the LTC2344 controller: arbitrates a periodic timer and a
// software request port, drives softspan/extTrig, and publishes tagged channel results.
//
// state | meaning
// IDLE  | waiting for a periodic tick or software request; grants round-robin on a tie
// SETUP | softspan driven, settling for SETTLE_CYCLES cycles
// TRIG  | extTrig high for one cycle
// WAIT  | waiting for dataRdy, bounded by TIMEOUT_CYCLES
// DONE  | resValid high for one cycle
module ltc2344_conv_scheduler #(
   parameter int SETTLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        serialClock,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] period,
   input  logic [11:0] softspanPeriodic,
   input  logic        reqValid,
   input  logic [11:0] reqSoftspan,
   output logic        reqReady,
   input  logic        clearFlags,
   output logic        extTrig,
   output logic [11:0] softspan,
   input  logic        dataRdy,
   input  logic [15:0] inData0,
   input  logic [15:0] inData1,
   input  logic [15:0] inData2,
   input  logic [15:0] inData3,
   output logic        resValid,
   output logic [63:0] resData,
   output logic        resSource,
   output logic        overrun,
   output logic        timeoutErr
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_TRIG  = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   logic [2:0]    state;
   logic [15:0]   timer;
   logic          timer_run;
   logic          pending;
   logic          last_grant;
   logic [3:0]    settle_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          reset_d;

   logic timer_on;
   logic expiry;
   logic can_grant;
   logic grant_sw;
   logic grant_per;
   logic tmo_hit;

   always_comb begin
      timer_on  = enable && (period != 16'd0);
      expiry    = timer_on && timer_run && (timer == 16'd0);
      // no grants in the reset cycle or the one right after it
      can_grant = (state == ST_IDLE) && !reset && !reset_d;
      grant_sw  = can_grant && reqValid && (!pending || !last_grant);
      grant_per = can_grant && pending && (!reqValid || last_grant);
      tmo_hit   = (state == ST_WAIT) && !dataRdy && (tmo_cnt == TMO_LAST);
      reqReady  = grant_sw;
      extTrig   = (state == ST_TRIG) && !reset;
      resValid  = (state == ST_DONE) && !reset;
   end

   always_ff @(posedge serialClock) begin
      reset_d <= reset;
      if (reset) begin
         state      <= ST_IDLE;
         timer      <= 16'd0;
         timer_run  <= 1'b0;
         pending    <= 1'b0;
         last_grant <= 1'b1;
         settle_cnt <= 4'd0;
         tmo_cnt    <= '0;
         softspan   <= 12'hFFF;
         resData    <= 64'd0;
         resSource  <= 1'b0;
         overrun    <= 1'b0;
         timeoutErr <= 1'b0;
      end else begin
         if (!timer_on) begin
            timer     <= 16'd0;
            timer_run <= 1'b0;
         end else if (!timer_run || timer == 16'd0) begin
            timer     <= period - 16'd1;
            timer_run <= 1'b1;
         end else begin
            timer <= timer - 16'd1;
         end

         // an expiry coinciding with a periodic grant leaves a fresh tick pending
         if (!timer_on)
            pending <= 1'b0;
         else if (expiry)
            pending <= 1'b1;
         else if (grant_per)
            pending <= 1'b0;

         if (expiry && pending)
            overrun <= 1'b1;
         else if (clearFlags)
            overrun <= 1'b0;

         if (tmo_hit)
            timeoutErr <= 1'b1;
         else if (clearFlags)
            timeoutErr <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (grant_sw || grant_per) begin
                  softspan   <= grant_sw ? reqSoftspan : softspanPeriodic;
                  resSource  <= grant_sw;
                  last_grant <= grant_sw;
                  settle_cnt <= SETTLE_LOAD;
                  state      <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (settle_cnt == 4'd0)
                  state <= ST_TRIG;
               else
                  settle_cnt <= settle_cnt - 4'd1;
            end
            ST_TRIG: begin
               tmo_cnt <= '0;
               state   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (dataRdy) begin
                  resData <= {inData3, inData2, inData1, inData0};
                  state   <= ST_DONE;
               end else if (tmo_cnt == TMO_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ltc2344_conv_scheduler.sv
// Scoreboard bench for ltc2344_conv_scheduler: a transaction-level model predicts each
// grant's trigger time, softspan and result; a monitor checks strobes against the queues.
module tb_ltc2344_conv_scheduler;
   localparam int SETTLE = 2;
   localparam int TMO    = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1, en = 1'b0, rv = 1'b0, clr = 1'b0, drdy = 1'b0;
   logic [15:0] per = 16'd0;
   logic [11:0] ssp = 12'd0, rss = 12'd0;
   logic [15:0] d0 = 16'd0, d1 = 16'd0, d2 = 16'd0, d3 = 16'd0;
   logic        reqReady, extTrig, resValid, resSource, overrun, timeoutErr;
   logic [11:0] softspan;
   logic [63:0] resData;

   always #5 clk = ~clk;

   ltc2344_conv_scheduler #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
      .serialClock(clk), .reset(rst), .enable(en), .period(per), .softspanPeriodic(ssp),
      .reqValid(rv), .reqSoftspan(rss), .reqReady(reqReady), .clearFlags(clr),
      .extTrig(extTrig), .softspan(softspan), .dataRdy(drdy),
      .inData0(d0), .inData1(d1), .inData2(d2), .inData3(d3),
      .resValid(resValid), .resData(resData), .resSource(resSource),
      .overrun(overrun), .timeoutErr(timeoutErr));

   typedef struct { int cyc; logic [11:0] ss; } trig_t;
   typedef struct { int cyc; logic src; logic [63:0] data; } res_t;
   trig_t trig_q[$];
   res_t  res_q[$];

   int n_checks = 0, n_fail = 0, cyc = 0;
   bit started = 1'b0, req_taken = 1'b0;

   // stimulus configuration, applied by step() at drive time
   bit          cfg_rst = 1'b1, cfg_en = 1'b0, cfg_garbage = 1'b1;
   logic [15:0] cfg_per = 16'd0;
   logic [11:0] cfg_ssp = 12'd0;
   int cfg_req_pct = 0, cfg_clr_pct = 0, cfg_tmo_pct = 0, cfg_jmin = 1, cfg_jmax = 1;

   // reference model state
   int          m_free = 0, m_next = 0, m_tmo_edge = -1, m_drv = -1, m_wlo = -10, m_whi = -10;
   int          m_cap_edge = -1;
   bit          m_pend = 0, m_run = 0, m_last = 1, m_ovr = 0, m_tmo = 0;
   logic [11:0] m_ss = 12'hFFF;
   logic [63:0] m_drv_data = 64'd0, m_res = 64'd0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      int e, t, j;
      bit on, exp_ev, gs, gp, set_ovr, set_tmo, in_wait;
      trig_t te;
      res_t  re;
      @(posedge clk);
      cyc++;
      #2;
      if (started) begin
         chk(overrun === m_ovr, "overrun", overrun, m_ovr);
         chk(timeoutErr === m_tmo, "timeout_err", timeoutErr, m_tmo);
         chk(softspan === m_ss, "softspan_hold", softspan, m_ss);
         chk(resData === m_res, "res_data_hold", resData, m_res);
         if (rst) begin
            chk(resSource === 1'b0, "reset_res_source", resSource, 0);
            chk(extTrig === 1'b0 && resValid === 1'b0, "reset_strobes", {extTrig, resValid}, 0);
         end
      end
      rst = cfg_rst; en = cfg_en; per = cfg_per; ssp = cfg_ssp;
      if (rst || req_taken) begin
         rv = 1'b0;
         req_taken = 1'b0;
      end
      if (!rv && !rst && $urandom_range(99) < cfg_req_pct) begin
         rv  = 1'b1;
         rss = 12'($urandom);
      end
      clr     = ($urandom_range(99) < cfg_clr_pct);
      in_wait = (cyc >= m_wlo) && (cyc <= m_whi);
      drdy    = in_wait ? (cyc == m_drv) : (cfg_garbage && $urandom_range(7) == 0);
      {d3, d2, d1, d0} = (cyc == m_drv) ? m_drv_data : {$urandom, $urandom};
      #1;
      e = cyc + 1;
      if (rst) begin
         chk(reqReady === 1'b0, "req_ready_reset", reqReady, 0);
         trig_q.delete();
         res_q.delete();
         m_free = e + 2; m_pend = 0; m_run = 0; m_last = 1; m_ovr = 0; m_tmo = 0;
         m_ss = 12'hFFF; m_tmo_edge = -1; m_cap_edge = -1; m_res = 64'd0;
         started = 1'b1;
      end else begin
         on = en && (per != 16'd0);
         exp_ev = 0;
         if (!on) m_run = 0;
         else if (!m_run) begin m_run = 1; m_next = e + int'(per); end
         else if (e == m_next) begin exp_ev = 1; m_next = e + int'(per); end
         gs = (e >= m_free) && rv && (!m_pend || !m_last);
         gp = (e >= m_free) && m_pend && (!rv || m_last);
         chk(reqReady === gs, "req_ready", reqReady, gs);
         if (e == m_cap_edge) m_res = m_drv_data;
         if (gs || gp) begin
            m_last = gs;
            m_ss   = gs ? rss : ssp;
            t      = e + SETTLE;
            te.cyc = t; te.ss = m_ss;
            trig_q.push_back(te);
            m_wlo = t + 1;
            if ($urandom_range(99) < cfg_tmo_pct) begin
               m_drv = -1; m_whi = t + TMO; m_tmo_edge = t + TMO + 1; m_free = t + TMO + 2;
            end else begin
               j = $urandom_range(cfg_jmax, cfg_jmin);
               m_drv = t + j; m_drv_data = {$urandom, $urandom};
               m_whi = t + j; m_cap_edge = t + j + 1; m_free = t + j + 3;
               re.cyc = t + j + 1; re.src = gs; re.data = m_drv_data;
               res_q.push_back(re);
            end
            if (gs) req_taken = 1'b1;
         end
         set_ovr = 0;
         if (!on) m_pend = 0;
         else if (exp_ev) begin set_ovr = m_pend; m_pend = 1; end
         else if (gp) m_pend = 0;
         set_tmo = (e == m_tmo_edge);
         m_ovr = set_ovr ? 1'b1 : (clr ? 1'b0 : m_ovr);
         m_tmo = set_tmo ? 1'b1 : (clr ? 1'b0 : m_tmo);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         while (trig_q.size() > 0 && trig_q[0].cyc < cyc) begin
            chk(extTrig === 1'b1, "trig_missing", cyc, trig_q[0].cyc);
            void'(trig_q.pop_front());
         end
         while (res_q.size() > 0 && res_q[0].cyc < cyc) begin
            chk(resValid === 1'b1, "res_missing", cyc, res_q[0].cyc);
            void'(res_q.pop_front());
         end
         if (extTrig === 1'b1) begin
            chk(trig_q.size() > 0, "trig_unexpected", 1, 0);
            if (trig_q.size() > 0) begin
               trig_t te;
               te = trig_q.pop_front();
               chk(te.cyc == cyc, "trig_cycle", cyc, te.cyc);
               chk(softspan === te.ss, "trig_softspan", softspan, te.ss);
            end
         end
         if (resValid === 1'b1) begin
            chk(res_q.size() > 0, "res_unexpected", 1, 0);
            if (res_q.size() > 0) begin
               res_t re;
               re = res_q.pop_front();
               chk(re.cyc == cyc, "res_cycle", cyc, re.cyc);
               chk(resSource === re.src, "res_source", resSource, re.src);
               chk(resData === re.data, "res_data", resData, re.data);
            end
         end
      end
   end

   task automatic wait_grant(input int limit);
      int n = 0;
      while (trig_q.size() == 0 && n < limit) begin
         step();
         n++;
      end
      chk(n < limit, "grant_wait_bound", n, limit);
   endtask

   task automatic do_reset();
      cfg_rst = 1'b1; cfg_en = 1'b0; cfg_req_pct = 0;
      step();
      cfg_rst = 1'b0;
      repeat (TMO + 10) step();
   endtask

   initial begin
      step(); step();
      cfg_rst = 1'b0;
      repeat (3) step();

      // periodic only
      cfg_en = 1'b1; cfg_per = 16'd200; cfg_ssp = 12'hB6D;
      cfg_jmin = 50; cfg_jmax = 50;
      repeat (1100) step();

      // software only
      cfg_en = 1'b0; cfg_req_pct = 30; cfg_jmin = 1; cfg_jmax = 20;
      repeat (800) step();

      // mixed traffic: ties, overruns, timeouts, flag clears
      cfg_en = 1'b1; cfg_req_pct = 40; cfg_jmin = 1; cfg_jmax = TMO; cfg_tmo_pct = 10; cfg_clr_pct = 3;
      for (int k = 0; k < 6; k++) begin
         cfg_per = 16'($urandom_range(60, 20));
         cfg_ssp = 12'($urandom);
         repeat (500) step();
      end

      // overrun with slow conversions, then clear
      cfg_req_pct = 0; cfg_tmo_pct = 0; cfg_clr_pct = 0;
      cfg_per = 16'd20; cfg_jmin = 60; cfg_jmax = 60;
      repeat (400) step();
      cfg_en = 1'b0;
      repeat (80) step();
      cfg_clr_pct = 100; step(); cfg_clr_pct = 0;
      repeat (5) step();

      // software timeouts, then captures exactly at the terminal cycle
      cfg_req_pct = 50; cfg_tmo_pct = 100;
      repeat (300) step();
      cfg_tmo_pct = 0; cfg_jmin = TMO; cfg_jmax = TMO;
      repeat (300) step();
      cfg_clr_pct = 100; step(); cfg_clr_pct = 0;

      // resets in SETUP and WAIT, with late dataRdy afterwards
      cfg_jmin = 40; cfg_jmax = 40;
      for (int k = 0; k < 4; k++) begin
         cfg_en = 1'b1; cfg_per = 16'($urandom_range(80, 30)); cfg_req_pct = 20;
         wait_grant(400);
         do_reset();
         cfg_en = 1'b1; cfg_req_pct = 20;
         wait_grant(400);
         repeat (5) step();
         do_reset();
      end
      cfg_jmin = 1; cfg_jmax = TMO; cfg_tmo_pct = 20;
      for (int k = 0; k < 6; k++) begin
         cfg_en = 1'b1; cfg_per = 16'($urandom_range(80, 30)); cfg_req_pct = 40;
         repeat ($urandom_range(150, 20)) step();
         do_reset();
      end

      // drain
      cfg_en = 1'b0; cfg_req_pct = 0;
      repeat (TMO + 20) step();
      chk(trig_q.size() == 0, "trig_queue_empty", trig_q.size(), 0);
      chk(res_q.size() == 0, "res_queue_empty", res_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
